// File: rtl/vtg_pkg.sv
// Shared timing types, standard video modes and the config validation rule
// for the programmable video timing generator.
package vtg_pkg;

    localparam int unsigned TW = 16;

    typedef struct packed {
        logic [TW-1:0] h_total;
        logic [TW-1:0] h_sync;
        logic [TW-1:0] h_bp;
        logic [TW-1:0] h_act;
        logic [TW-1:0] v_total;
        logic [TW-1:0] v_sync;
        logic [TW-1:0] v_bp;
        logic [TW-1:0] v_act;
        logic          hs_pol;
        logic          vs_pol;
    } vtg_timing_t;

    typedef enum logic {
        CFG_IDLE,
        CFG_PENDING
    } cfg_state_t;

    localparam vtg_timing_t MODE_640X480 = '{
        h_total: 16'd800,  h_sync: 16'd96, h_bp: 16'd40,  h_act: 16'd640,
        v_total: 16'd525,  v_sync: 16'd2,  v_bp: 16'd25,  v_act: 16'd480,
        hs_pol: 1'b1, vs_pol: 1'b1};

    localparam vtg_timing_t MODE_1280X720 = '{
        h_total: 16'd1650, h_sync: 16'd40, h_bp: 16'd220, h_act: 16'd1280,
        v_total: 16'd750,  v_sync: 16'd5,  v_bp: 16'd20,  v_act: 16'd720,
        hs_pol: 1'b1, vs_pol: 1'b1};

    localparam vtg_timing_t MODE_1920X1080 = '{
        h_total: 16'd2200, h_sync: 16'd44, h_bp: 16'd148, h_act: 16'd1920,
        v_total: 16'd1125, v_sync: 16'd5,  v_bp: 16'd36,  v_act: 16'd1080,
        hs_pol: 1'b1, vs_pol: 1'b1};

    // Sums are widened by two bits so three maximal fields cannot wrap.
    function automatic logic timing_ok(input vtg_timing_t t);
        logic [TW+1:0] hsum;
        logic [TW+1:0] vsum;
        hsum = (TW+2)'(t.h_sync) + (TW+2)'(t.h_bp) + (TW+2)'(t.h_act);
        vsum = (TW+2)'(t.v_sync) + (TW+2)'(t.v_bp) + (TW+2)'(t.v_act);
        return (t.h_sync != '0) && (t.h_act != '0) && (hsum < (TW+2)'(t.h_total)) &&
               (t.v_sync != '0) && (t.v_act != '0) && (vsum < (TW+2)'(t.v_total));
    endfunction

endpackage

// File: rtl/vtg_cfg_shadow.sv
// Config handshake with validation, pending/active register sets and a
// frame-boundary apply strobe.
module vtg_cfg_shadow import vtg_pkg::*; #(
    parameter vtg_timing_t DEF = MODE_640X480
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  vtg_timing_t cfg_in,
    output logic        cfg_err,
    input  logic        apply,
    output vtg_timing_t active
);

    cfg_state_t  state, state_nx;
    vtg_timing_t pend;
    logic        load_pend, load_act, err_nx;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= CFG_IDLE;
            pend    <= DEF;
            active  <= DEF;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nx;
            cfg_err <= err_nx;
            if (load_pend) pend   <= cfg_in;
            if (load_act)  active <= pend;
        end
    end

    always_comb begin
        state_nx  = state;
        load_pend = 1'b0;
        load_act  = 1'b0;
        err_nx    = 1'b0;
        cfg_ready = (state == CFG_IDLE);
        case (state)
            CFG_IDLE: begin
                if (cfg_valid) begin
                    if (timing_ok(cfg_in)) begin
                        load_pend = 1'b1;
                        state_nx  = CFG_PENDING;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            CFG_PENDING: begin
                if (apply) begin
                    load_act = 1'b1;
                    state_nx = CFG_IDLE;
                end
            end
            default: state_nx = CFG_IDLE;
        endcase
    end

endmodule

// File: rtl/vtg_prog.sv
// Runtime-programmable video timing generator: h/v counters and registered
// sync / data-enable / coordinate decode against the active timing set.
module vtg_prog import vtg_pkg::*; #(
    parameter int          X_BITS      = 12,
    parameter int          Y_BITS      = 12,
    parameter int unsigned DEF_H_TOTAL = 800,
    parameter int unsigned DEF_H_SYNC  = 96,
    parameter int unsigned DEF_H_BP    = 40,
    parameter int unsigned DEF_H_ACT   = 640,
    parameter int unsigned DEF_V_TOTAL = 525,
    parameter int unsigned DEF_V_SYNC  = 2,
    parameter int unsigned DEF_V_BP    = 25,
    parameter int unsigned DEF_V_ACT   = 480,
    parameter bit          DEF_HS_POL  = 1'b1,
    parameter bit          DEF_VS_POL  = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [X_BITS-1:0] cfg_h_total,
    input  logic [X_BITS-1:0] cfg_h_sync,
    input  logic [X_BITS-1:0] cfg_h_bp,
    input  logic [X_BITS-1:0] cfg_h_act,
    input  logic [Y_BITS-1:0] cfg_v_total,
    input  logic [Y_BITS-1:0] cfg_v_sync,
    input  logic [Y_BITS-1:0] cfg_v_bp,
    input  logic [Y_BITS-1:0] cfg_v_act,
    input  logic              cfg_hs_pol,
    input  logic              cfg_vs_pol,
    output logic              cfg_err,
    output logic              hs_out,
    output logic              vs_out,
    output logic              de_out,
    output logic [X_BITS-1:0] x_act,
    output logic [Y_BITS-1:0] y_act,
    output logic              sof,
    output logic              eol
);

    // Fields are zero-extended and validated, so wider arithmetic matches
    // X_BITS+1 / Y_BITS+1 results exactly.
    localparam int CW = TW + 1;

    localparam vtg_timing_t DEF_T = '{
        h_total: TW'(DEF_H_TOTAL), h_sync: TW'(DEF_H_SYNC),
        h_bp:    TW'(DEF_H_BP),    h_act:  TW'(DEF_H_ACT),
        v_total: TW'(DEF_V_TOTAL), v_sync: TW'(DEF_V_SYNC),
        v_bp:    TW'(DEF_V_BP),    v_act:  TW'(DEF_V_ACT),
        hs_pol:  DEF_HS_POL,       vs_pol: DEF_VS_POL};

    vtg_timing_t       cfg_in, act;
    logic [X_BITS-1:0] h;
    logic [Y_BITS-1:0] v;
    logic [CW-1:0]     h_ext, hde_beg, hde_end, v_ext, vde_beg, vde_end;
    logic              h_last, v_last, de_nx, apply;

    assign cfg_in = '{
        h_total: TW'(cfg_h_total), h_sync: TW'(cfg_h_sync),
        h_bp:    TW'(cfg_h_bp),    h_act:  TW'(cfg_h_act),
        v_total: TW'(cfg_v_total), v_sync: TW'(cfg_v_sync),
        v_bp:    TW'(cfg_v_bp),    v_act:  TW'(cfg_v_act),
        hs_pol:  cfg_hs_pol,       vs_pol: cfg_vs_pol};

    vtg_cfg_shadow #(.DEF(DEF_T)) u_shadow (
        .clk       (clk),
        .rstn      (rstn),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_in    (cfg_in),
        .cfg_err   (cfg_err),
        .apply     (apply),
        .active    (act)
    );

    assign h_ext   = CW'(h);
    assign v_ext   = CW'(v);
    assign hde_beg = CW'(act.h_sync) + CW'(act.h_bp);
    assign hde_end = hde_beg + CW'(act.h_act);
    assign vde_beg = CW'(act.v_sync) + CW'(act.v_bp);
    assign vde_end = vde_beg + CW'(act.v_act);
    assign h_last  = (h_ext == CW'(act.h_total) - CW'(1));
    assign v_last  = (v_ext == CW'(act.v_total) - CW'(1));
    assign de_nx   = (h_ext >= hde_beg) && (h_ext < hde_end) &&
                     (v_ext >= vde_beg) && (v_ext < vde_end);
    assign apply   = !en || (h_last && v_last);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            h      <= '0;
            v      <= '0;
            hs_out <= !DEF_HS_POL;
            vs_out <= !DEF_VS_POL;
            de_out <= 1'b0;
            x_act  <= '0;
            y_act  <= '0;
            sof    <= 1'b0;
            eol    <= 1'b0;
        end else if (!en) begin
            h      <= '0;
            v      <= '0;
            hs_out <= !act.hs_pol;
            vs_out <= !act.vs_pol;
            de_out <= 1'b0;
            x_act  <= '0;
            y_act  <= '0;
            sof    <= 1'b0;
            eol    <= 1'b0;
        end else begin
            if (h_last) begin
                h <= '0;
                v <= v_last ? '0 : v + Y_BITS'(1);
            end else begin
                h <= h + X_BITS'(1);
            end
            hs_out <= ((h_ext < CW'(act.h_sync)) == act.hs_pol);
            vs_out <= ((v_ext < CW'(act.v_sync)) == act.vs_pol);
            de_out <= de_nx;
            x_act  <= de_nx ? X_BITS'(h_ext - hde_beg) : '0;
            y_act  <= de_nx ? Y_BITS'(v_ext - vde_beg) : '0;
            sof    <= (h == '0) && (v == '0);
            eol    <= de_nx && (h_ext == hde_end - CW'(1));
        end
    end

endmodule

// File: tb/tb_vtg_prog.sv
// Directed bench for vtg_prog using reduced default timing
// (H 20/3/2/12, V 10/2/2/5, 200-clock frames) to keep runs short.
module tb_vtg_prog;

    localparam int XB = 12;
    localparam int YB = 12;

    logic          clk = 1'b0;
    logic          rstn, en, cfg_valid, cfg_ready, cfg_hs_pol, cfg_vs_pol, cfg_err;
    logic [XB-1:0] cfg_h_total, cfg_h_sync, cfg_h_bp, cfg_h_act, x_act;
    logic [YB-1:0] cfg_v_total, cfg_v_sync, cfg_v_bp, cfg_v_act, y_act;
    logic          hs_out, vs_out, de_out, sof, eol;

    int n_vec = 0;
    int n_err = 0;
    int s_sof, s_de, s_hs, s_vs, s_eol, s_first_de, s_eol_x, s_last_y, s_bad;
    int cnt, sof_seen;

    vtg_prog #(
        .X_BITS(XB), .Y_BITS(YB),
        .DEF_H_TOTAL(20), .DEF_H_SYNC(3), .DEF_H_BP(2), .DEF_H_ACT(12),
        .DEF_V_TOTAL(10), .DEF_V_SYNC(2), .DEF_V_BP(2), .DEF_V_ACT(5),
        .DEF_HS_POL(1'b1), .DEF_VS_POL(1'b1)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_h_total(cfg_h_total), .cfg_h_sync(cfg_h_sync),
        .cfg_h_bp(cfg_h_bp), .cfg_h_act(cfg_h_act),
        .cfg_v_total(cfg_v_total), .cfg_v_sync(cfg_v_sync),
        .cfg_v_bp(cfg_v_bp), .cfg_v_act(cfg_v_act),
        .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol),
        .cfg_err(cfg_err), .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out),
        .x_act(x_act), .y_act(y_act), .sof(sof), .eol(eol)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int ht, hs, hb, ha, vt, vs, vb, va, input logic hp, vp);
        cfg_h_total = XB'(ht); cfg_h_sync = XB'(hs); cfg_h_bp = XB'(hb); cfg_h_act = XB'(ha);
        cfg_v_total = YB'(vt); cfg_v_sync = YB'(vs); cfg_v_bp = YB'(vb); cfg_v_act = YB'(va);
        cfg_hs_pol  = hp;      cfg_vs_pol = vp;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".hs"}, hs_out, 0);
        chk({tag, ".vs"}, vs_out, 0);
        chk({tag, ".de"}, de_out, 0);
        chk({tag, ".x"}, x_act, 0);
        chk({tag, ".y"}, y_act, 0);
        chk({tag, ".sof"}, sof, 0);
        chk({tag, ".eol"}, eol, 0);
        chk({tag, ".err"}, cfg_err, 0);
        chk({tag, ".ready"}, cfg_ready, 1);
    endtask

    // Current sample is frame index 0; steps n-1 more times.
    task automatic stats(input int n, input logic hp, input logic vp);
        s_sof = 0; s_de = 0; s_hs = 0; s_vs = 0; s_eol = 0;
        s_first_de = -1; s_eol_x = -1; s_last_y = -1; s_bad = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) step();
            if (sof) s_sof++;
            if (de_out) begin
                s_de++;
                if (s_first_de < 0) s_first_de = i;
            end else if (x_act != '0 || y_act != '0) begin
                s_bad++;
            end
            if (hs_out == hp) s_hs++;
            if (vs_out == vp) s_vs++;
            if (eol) begin
                s_eol++;
                s_eol_x  = int'(x_act);
                s_last_y = int'(y_act);
            end
        end
    endtask

    task automatic chk_frame(input string tag, input int de_n, hs_n, vs_n, eol_n, first, ex, ly);
        chk({tag, ".sof_cnt"}, s_sof, 1);
        chk({tag, ".de_cnt"}, s_de, de_n);
        chk({tag, ".hs_cnt"}, s_hs, hs_n);
        chk({tag, ".vs_cnt"}, s_vs, vs_n);
        chk({tag, ".eol_cnt"}, s_eol, eol_n);
        chk({tag, ".first_de"}, s_first_de, first);
        chk({tag, ".eol_x"}, s_eol_x, ex);
        chk({tag, ".last_y"}, s_last_y, ly);
        chk({tag, ".xy_outside"}, s_bad, 0);
    endtask

    task automatic wait_sof(input int limit, output int c);
        c = 0;
        do begin
            step();
            c++;
        end while (!sof && c < limit);
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; cfg_valid = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
        repeat (3) step();
        chk_reset("rst");

        // Defaults: 200-clock frames
        rstn = 1'b1;
        step();
        en = 1'b1;
        step();
        chk("def.sof", sof, 1);
        stats(200, 1'b1, 1'b1);
        chk_frame("def", 60, 30, 40, 5, 85, 11, 4);
        step();
        chk("def.period", sof, 1);

        // Small timing loaded while running defaults
        set_cfg(10, 2, 2, 4, 6, 1, 1, 3, 1'b1, 1'b1);
        cfg_valid = 1'b1;
        step();
        chk("run.ready_drop", cfg_ready, 0);
        chk("run.err", cfg_err, 0);
        cfg_valid = 1'b0;
        cnt = 1; sof_seen = 0;
        while (!cfg_ready && cnt < 400) begin
            step();
            cnt++;
            if (sof) sof_seen++;
        end
        chk("run.ready_back", cnt, 199);
        chk("run.no_early_sof", sof_seen, 0);
        step();
        chk("run.sof", sof, 1);
        stats(60, 1'b1, 1'b1);
        chk_frame("small", 12, 12, 10, 3, 24, 3, 2);
        step();
        chk("small.period", sof, 1);

        // Invalid config: front porch 0
        set_cfg(10, 2, 2, 6, 6, 1, 1, 3, 1'b1, 1'b1);
        cfg_valid = 1'b1;
        step();
        chk("bad.err", cfg_err, 1);
        chk("bad.ready", cfg_ready, 1);
        cfg_valid = 1'b0;
        step();
        chk("bad.err_clear", cfg_err, 0);
        chk("bad.ready2", cfg_ready, 1);
        wait_sof(100, cnt);
        chk("bad.period", cnt, 58);
        stats(60, 1'b1, 1'b1);
        chk_frame("bad", 12, 12, 10, 3, 24, 3, 2);

        // Active-low syncs loaded while disabled
        en = 1'b0;
        step();
        set_cfg(10, 2, 2, 4, 6, 1, 1, 3, 1'b0, 1'b0);
        cfg_valid = 1'b1;
        step();
        chk("pol.ready_drop", cfg_ready, 0);
        cfg_valid = 1'b0;
        step();
        chk("pol.ready_back", cfg_ready, 1);
        step();
        chk("pol.idle_hs", hs_out, 1);
        chk("pol.idle_vs", vs_out, 1);
        chk("pol.idle_de", de_out, 0);
        en = 1'b1;
        step();
        chk("pol.sof", sof, 1);
        stats(60, 1'b0, 1'b0);
        chk_frame("pol", 12, 12, 10, 3, 24, 3, 2);
        step();
        chk("pol.period", sof, 1);

        // Reset mid-frame with a pending config
        set_cfg(16, 2, 2, 8, 8, 1, 1, 4, 1'b1, 1'b1);
        cfg_valid = 1'b1;
        step();
        chk("rst2.pending", cfg_ready, 0);
        cfg_valid = 1'b0;
        repeat (5) step();
        rstn = 1'b0;
        step();
        chk_reset("rst2");
        rstn = 1'b1;
        step();
        chk("rst2.sof", sof, 1);
        stats(200, 1'b1, 1'b1);
        chk_frame("rst2", 60, 30, 40, 5, 85, 11, 4);
        step();
        chk("rst2.period", sof, 1);
        wait_sof(300, cnt);
        chk("rst2.period2", cnt, 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
